// File: rtl/inst_mem_responder_way0_if.sv
// ---------------------------------------------------------------------------
// inst_mem_responder_way0_if
//   Fetch bus between the way0 IFU (master) and the instruction memory
//   responder (slave).
//   request_i   IFU -> mem  fetch request, level, held until dataOk_o/flush
//   instAddr_i  IFU -> mem  byte fetch address
//   flush_i     IFU -> mem  jump/flush, cancels the pending fetch
//   dataOk_o    mem -> IFU  one-cycle strobe, inst_o/fault_o valid
//   inst_o      mem -> IFU  fetched instruction, held between strobes
//   fault_o     mem -> IFU  misaligned / out-of-range qualifier of dataOk_o
//   busy_o      mem -> IFU  a fetch is captured and not yet answered
// ---------------------------------------------------------------------------
interface inst_mem_responder_way0_if;
    logic        request_i;
    logic [31:0] instAddr_i;
    logic        flush_i;
    logic        dataOk_o;
    logic [31:0] inst_o;
    logic        fault_o;
    logic        busy_o;

    modport master (
        output request_i, instAddr_i, flush_i,
        input  dataOk_o, inst_o, fault_o, busy_o
    );

    modport slave (
        input  request_i, instAddr_i, flush_i,
        output dataOk_o, inst_o, fault_o, busy_o
    );
endinterface

// File: rtl/inst_mem_responder_way0.sv
// ---------------------------------------------------------------------------
// inst_mem_responder_way0
//   Memory-side responder for the way0 instruction-fetch port. A captured
//   fetch is answered with one 32-bit word and a one-cycle dataOk_o strobe
//   LATENCY cycles after capture. A flush from the core drops the fetch.
//   The backing word array is loaded through a separate preload port.
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset (array contents not reset)
//   bus         fetch bus, slave side (see inst_mem_responder_way0_if)
//   memWe_i     preload write enable
//   memWaddr_i  preload word index
//   memWdata_i  preload data
// Parameters:
//   DEPTH_LOG2  log2 of array depth in words (1..29)
//   LATENCY     capture-to-strobe cycles (1..15)
//   BASE_ADDR   byte address of word 0
//   FAULT_INST  instruction returned on a faulting fetch
// ---------------------------------------------------------------------------
module inst_mem_responder_way0 #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] FAULT_INST = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  reset_n,
    inst_mem_responder_way0_if.slave bus,
    input  logic                  memWe_i,
    input  logic [DEPTH_LOG2-1:0] memWaddr_i,
    input  logic [31:0]           memWdata_i
);

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [31:0] SPAN     = 32'd4 << DEPTH_LOG2;
    localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q;
    logic        capture;
    logic        resp_en;

    logic        data_ok_q;
    logic [31:0] inst_q;
    logic        fault_q;
    logic        busy_q;

    logic [31:0] mem [DEPTH];

    // Address looked up on the response edge. With LATENCY=1 the response
    // edge is also the capture edge, so addr_q is not yet loaded and the
    // live bus address must be used.
    logic [31:0]           fetch_addr;
    logic [31:0]           off;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  fault;

    assign fetch_addr = (state_q == IDLE) ? bus.instAddr_i : addr_q;
    assign off        = fetch_addr - BASE_ADDR;
    assign idx        = off[DEPTH_LOG2+1:2];
    assign fault      = (fetch_addr[1:0] != 2'b00) ||
                        (fetch_addr < BASE_ADDR)   ||
                        (off >= SPAN);

    always_comb begin
        // NOTE: every signal gets a default here so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        resp_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A flush in the same cycle as a request suppresses capture.
                if (bus.request_i && !bus.flush_i) begin
                    capture = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        resp_en = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (bus.flush_i) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    resp_en = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            // The strobe is already out; the request is ignored this cycle
            // because the IFU only advances its address on dataOk_o.
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= 32'd0;
            data_ok_q <= 1'b0;
            inst_q    <= 32'd0;
            fault_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            if (capture) begin
                addr_q <= bus.instAddr_i;
            end
            data_ok_q <= resp_en;
            fault_q   <= resp_en && fault;
            busy_q    <= (state_d == WAIT);
            if (resp_en) begin
                inst_q <= fault ? FAULT_INST : mem[idx];
            end
        end
    end

    // NOTE: the array is deliberately left out of reset so it maps onto RAM;
    // since the write is non-blocking in its own process, a response read of
    // the word being written on the same edge returns the old contents.
    always_ff @(posedge clk) begin
        if (memWe_i) begin
            mem[memWaddr_i] <= memWdata_i;
        end
    end

    assign bus.dataOk_o = data_ok_q;
    assign bus.inst_o   = inst_q;
    assign bus.fault_o  = fault_q;
    assign bus.busy_o   = busy_q;

endmodule
